// File: rtl/rr_mux_arbiter.sv
// rtl/rr_mux_arbiter.sv - round-robin owner arbiter driving a shared N:1 data mux
module rr_mux_arbiter #(
    parameter int N        = 4,
    parameter int DW       = 8,
    parameter int MAX_HOLD = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N-1:0]         req,
    input  logic [N*DW-1:0]      in_data,
    output logic [N-1:0]         gnt,
    output logic [$clog2(N)-1:0] gnt_id,
    output logic                 busy,
    output logic [DW-1:0]        out_data,
    output logic                 out_valid
);

    localparam int IW = $clog2(N);
    localparam int HW = $clog2(MAX_HOLD) + 1;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t        state, state_next;
    logic [IW-1:0] last, last_next;
    logic [HW-1:0] hold, hold_next;
    logic [N-1:0]  gnt_next;
    logic [IW-1:0] gnt_id_next;
    logic          busy_next;

    logic          win_found;
    logic [IW-1:0] win_id;
    logic [IW-1:0] cand;
    logic          release_now;

    // Rotating priority scan: the requester just after the last owner goes first.
    always_comb begin
        win_found = 1'b0;
        win_id    = '0;
        cand      = '0;
        for (int k = 1; k <= N; k++) begin
            cand = IW'((int'(last) + k) % N);
            if (!win_found && req[cand]) begin
                win_found = 1'b1;
                win_id    = cand;
            end
        end
    end

    // Owner gives up the mux when it drops its request or its hold budget runs out.
    assign release_now = !req[gnt_id] || (hold == HW'(MAX_HOLD - 1));

    // Next-state and next-output logic for the ownership FSM.
    always_comb begin
        state_next  = state;
        last_next   = last;
        hold_next   = hold;
        gnt_next    = gnt;
        gnt_id_next = gnt_id;
        busy_next   = busy;
        case (state)
            IDLE: begin
                if (win_found) begin
                    state_next         = GRANT;
                    gnt_next           = '0;
                    gnt_next[win_id]   = 1'b1;
                    gnt_id_next        = win_id;
                    busy_next          = 1'b1;
                    hold_next          = '0;
                end
            end
            GRANT: begin
                hold_next = hold + HW'(1);
                if (release_now) begin
                    state_next = IDLE;
                    last_next  = gnt_id;
                    gnt_next   = '0;
                    busy_next  = 1'b0;
                    hold_next  = '0;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // FSM state and registered grant outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            last   <= IW'(N - 1);
            hold   <= '0;
            gnt    <= '0;
            gnt_id <= '0;
            busy   <= 1'b0;
        end else begin
            state  <= state_next;
            last   <= last_next;
            hold   <= hold_next;
            gnt    <= gnt_next;
            gnt_id <= gnt_id_next;
            busy   <= busy_next;
        end
    end

    // Registered mux output; data is kept while no one owns the mux.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_data  <= '0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= busy;
            if (busy) begin
                out_data <= in_data[int'(gnt_id)*DW +: DW];
            end
        end
    end

endmodule
